// File: rtl/spi_reg_ctrl_if.sv
// Bundle of SPI-slave byte handshake and register-bus signals shared by
// the controller (slave side) and whatever drives it (master side).
interface spi_reg_ctrl_if;
    logic       ssel;
    logic       byteReceived;
    logic [7:0] receivedData;
    logic       txLoad;
    logic [7:0] txData;
    logic [6:0] regAddr;
    logic [7:0] regWData;
    logic       regWe;
    logic       regRe;
    logic [7:0] regRData;
    logic       overrun;

    modport slave (
        input  ssel, byteReceived, receivedData, regRData,
        output txLoad, txData, regAddr, regWData, regWe, regRe, overrun
    );

    modport master (
        output ssel, byteReceived, receivedData, regRData,
        input  txLoad, txData, regAddr, regWData, regWe, regRe, overrun
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: turns a byte stream (command byte plus
// data or dummy bytes) into register writes/reads and feeds read data back.
module spi_reg_ctrl (
    input  logic           clk,
    input  logic           rst,
    spi_reg_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_LOAD
    } state_t;

    state_t     state;
    logic [6:0] addr;
    logic       ssel_q;
    logic       tx_load;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       overrun;

    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        return a + 7'd1;
    endfunction

    assign bus.txLoad   = tx_load;
    assign bus.txData   = tx_data;
    assign bus.regAddr  = reg_addr;
    assign bus.regWData = reg_wdata;
    assign bus.regWe    = reg_we;
    assign bus.regRe    = reg_re;
    assign bus.overrun  = overrun;

    // ssel_q clears on reset so a frame only starts after ssel has been seen
    // high again; this stops a reset inside a frame from resuming mid-stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 7'd0;
            ssel_q    <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= 8'd0;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ssel_q  <= bus.ssel;
            tx_load <= 1'b0;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            if (bus.ssel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ssel_q) begin
                            state   <= CMD;
                            tx_load <= 1'b1;
                            tx_data <= 8'hA5;
                            overrun <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (bus.byteReceived) begin
                            addr <= bus.receivedData[6:0];
                            if (bus.receivedData[7]) begin
                                // regRe is registered, so it is raised on entry
                                // and is high for exactly the RD_REQ cycle.
                                state    <= RD_REQ;
                                reg_re   <= 1'b1;
                                reg_addr <= bus.receivedData[6:0];
                            end else begin
                                state <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (bus.byteReceived) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= addr;
                            reg_wdata <= bus.receivedData;
                            addr      <= addr_inc(addr);
                        end
                    end
                    RD_REQ: begin
                        state <= RD_WAIT;
                        if (bus.byteReceived) begin
                            overrun <= 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        // regRData is valid now, one cycle after regRe.
                        state   <= RD_LOAD;
                        tx_data <= bus.regRData;
                        tx_load <= 1'b1;
                        addr    <= addr_inc(addr);
                        if (bus.byteReceived) begin
                            overrun <= 1'b1;
                        end
                    end
                    RD_LOAD: begin
                        if (bus.byteReceived) begin
                            state    <= RD_REQ;
                            reg_re   <= 1'b1;
                            reg_addr <= addr;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: strobe events are queued with their due
// cycle when stimulus is driven and matched as the DUT raises them.
module tb_spi_reg_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data appears exactly one cycle after regRe.
    always @(posedge clk) begin
        if (bus.regRe === 1'b1) bus.regRData <= {1'b0, bus.regAddr} + 8'h40;
        else                    bus.regRData <= 8'hEE;
    end

    typedef struct packed {
        logic [31:0] cyc;
        logic [16:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] pack(input logic [1:0] k, input logic [6:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    task automatic expect_ev(input logic [1:0] k, input logic [6:0] a, input logic [7:0] d, input int at);
        exp_t e;
        e.cyc = at;
        e.val = pack(k, a, d);
        sb.push_back(e);
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int   nstb;
        logic [16:0] obs;
        exp_t e;
        nstb = int'(bus.regWe === 1'b1) + int'(bus.regRe === 1'b1) + int'(bus.txLoad === 1'b1);
        while (sb.size() > 0 && int'(sb[0].cyc) < cyc) begin
            e = sb.pop_front();
            chk("missed_event_cycle", cyc, e.cyc);
        end
        if (nstb > 0) begin
            chk("strobe_exclusive", nstb, 1);
            if (bus.regWe === 1'b1)      obs = pack(2'd0, bus.regAddr, bus.regWData);
            else if (bus.regRe === 1'b1) obs = pack(2'd1, bus.regAddr, 8'h00);
            else                         obs = pack(2'd2, 7'h00, bus.txData);
            if (sb.size() == 0) begin
                chk("spurious_strobe", nstb, 0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_value", obs, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int at);
        at = cyc;
        bus.byteReceived = 1'b1;
        bus.receivedData = b;
        tick();
        bus.byteReceived = 1'b0;
    endtask

    task automatic frame_start();
        bus.ssel = 1'b0;
        expect_ev(2'd2, 7'h00, 8'hA5, cyc + 1);
        tick();
    endtask

    task automatic frame_end();
        bus.ssel = 1'b1;
        tick();
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_regAddr"}, bus.regAddr, 0);
        chk({tag, "_regWData"}, bus.regWData, 0);
        chk({tag, "_txData"}, bus.txData, 0);
        chk({tag, "_strobes"}, {bus.regWe, bus.regRe, bus.txLoad}, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
    endtask

    initial begin
        int at;
        rst = 1'b1;
        bus.ssel = 1'b1;
        bus.byteReceived = 1'b0;
        bus.receivedData = 8'h00;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // Write burst
        frame_start();
        send(8'h05, at);
        idle(1);
        send(8'h11, at); expect_ev(2'd0, 7'h05, 8'h11, at + 1);
        send(8'h22, at); expect_ev(2'd0, 7'h06, 8'h22, at + 1);
        idle(2);
        frame_end();

        // Read burst with one dummy byte
        frame_start();
        send(8'h83, at);
        expect_ev(2'd1, 7'h03, 8'h00, at + 1);
        expect_ev(2'd2, 7'h00, 8'h43, at + 3);
        idle(5);
        chk("read_txData_hold", bus.txData, 8'h43);
        send(8'h00, at);
        expect_ev(2'd1, 7'h04, 8'h00, at + 1);
        expect_ev(2'd2, 7'h00, 8'h44, at + 3);
        idle(5);
        frame_end();

        // Address wrap, then ssel rising together with a data byte
        frame_start();
        send(8'h7F, at);
        send(8'h3C, at); expect_ev(2'd0, 7'h7F, 8'h3C, at + 1);
        send(8'hC3, at); expect_ev(2'd0, 7'h00, 8'hC3, at + 1);
        idle(1);
        bus.ssel = 1'b1;
        bus.byteReceived = 1'b1;
        bus.receivedData = 8'h77;
        tick();
        bus.byteReceived = 1'b0;
        idle(2);
        chk("wrap_hold_regWData", bus.regWData, 8'hC3);

        // Abort during RD_WAIT
        frame_start();
        send(8'h90, at);
        expect_ev(2'd1, 7'h10, 8'h00, at + 1);
        tick();
        bus.ssel = 1'b1;
        idle(4);
        frame_start();
        idle(1);
        frame_end();

        // Overrun: byte during RD_REQ
        frame_start();
        chk("overrun_clear", bus.overrun, 0);
        send(8'h81, at);
        expect_ev(2'd1, 7'h01, 8'h00, at + 1);
        expect_ev(2'd2, 7'h00, 8'h41, at + 3);
        send(8'h55, at);
        chk("overrun_set", bus.overrun, 1);
        idle(3);
        chk("overrun_sticky", bus.overrun, 1);
        frame_end();
        chk("overrun_idle", bus.overrun, 1);
        frame_start();
        chk("overrun_new_frame", bus.overrun, 0);
        frame_end();

        // Reset in the middle of a write
        frame_start();
        send(8'h20, at);
        send(8'h33, at); expect_ev(2'd0, 7'h20, 8'h33, at + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midreset");
        idle(1);
        send(8'h44, at);
        send(8'h45, at);
        idle(2);
        chk("midreset_ignored_addr", bus.regAddr, 0);
        chk("midreset_ignored_wdata", bus.regWData, 0);
        bus.ssel = 1'b1;
        tick();
        frame_start();
        send(8'h10, at);
        send(8'h99, at); expect_ev(2'd0, 7'h10, 8'h99, at + 1);
        idle(2);
        frame_end();

        idle(4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
